// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch-side PC / redirect controller.
// The flush counter sizing is also used by the data-side flush logic.
package branch_redirect_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   localparam int unsigned PC_INCR          = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [1:0]  ALIGN_MASK       = 2'b11;
   // Wide enough for FLUSH_CYCLES-1 over the legal 1..7 range
   localparam int unsigned FLUSH_CNT_W      = 3;

   function automatic logic is_word_aligned(input logic [1:0] low_bits);
      return (low_bits & ALIGN_MASK) == 2'b00;
   endfunction

endpackage

// File: rtl/redirect_flush_counter.sv
// Loadable down-counter with zero flag; it stops at zero and never wraps.
// A load takes priority over a decrement issued in the same cycle.
module redirect_flush_counter
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int unsigned W = FLUSH_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Fetch-side PC owner: issues sequential fetches under static predict-not-taken.
// Resolved taken branches/jumps redirect the PC and flush IF/ID; branch statistics are counted.
module branch_redirect_ctrl
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = DEFAULT_RESET_PC,
   parameter int unsigned     FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            br_valid,
   input  logic            br_taken,
   input  logic [XLEN-1:0] br_target,
   input  logic            jmp_valid,
   input  logic [XLEN-1:0] jmp_target,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   output logic            fetch_valid,
   output logic [XLEN-1:0] fetch_pc,
   output logic            flush_if,
   output logic            flush_id,
   output logic            misalign_err,
   output logic [31:0]     br_count,
   output logic [31:0]     taken_count
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            fetch_valid_q, fetch_valid_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            misalign_q, misalign_d;
   logic [31:0]     br_count_q, br_count_d;
   logic [31:0]     taken_count_q, taken_count_d;

   logic            redirect_req;
   logic [XLEN-1:0] redirect_target;
   logic            target_aligned;
   logic            redirect_live;
   logic            redirect_ok;
   logic            advance;
   logic            flush_load;
   logic            flush_dec;
   logic            flush_zero;

   // Jump wins over a simultaneous taken branch; BOOT ignores redirects entirely
   assign redirect_req    = jmp_valid | (br_valid & br_taken);
   assign redirect_target = jmp_valid ? jmp_target : br_target;
   assign target_aligned  = is_word_aligned(redirect_target[1:0]);
   assign redirect_live   = redirect_req & (state_q != ST_BOOT);
   assign redirect_ok     = redirect_live & target_aligned;

   assign imem_req = (state_q == ST_FETCH) & ~stall;
   // Any redirect attempt, even a rejected misaligned one, holds the PC
   assign advance  = imem_req & imem_ready & ~redirect_live;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_valid_d = 1'b0;
      fetch_pc_d    = fetch_pc_q;
      flush_load    = 1'b0;
      flush_dec     = 1'b0;
      misalign_d    = redirect_live & ~target_aligned;
      unique case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (redirect_ok) begin
               pc_d       = redirect_target;
               state_d    = ST_FLUSH;
               flush_load = 1'b1;
            end else if (advance) begin
               pc_d          = pc_q + XLEN'(PC_INCR);
               fetch_valid_d = 1'b1;
               fetch_pc_d    = pc_q;
            end
         end
         ST_FLUSH: begin
            if (redirect_ok) begin
               pc_d       = redirect_target;
               flush_load = 1'b1;
            end else if (flush_zero) begin
               state_d = ST_FETCH;
            end else begin
               flush_dec = 1'b1;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_comb begin
      br_count_d    = br_count_q;
      taken_count_d = taken_count_q;
      if (br_valid) begin
         br_count_d = br_count_q + 32'd1;
         if (br_taken) begin
            taken_count_d = taken_count_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_PC;
         fetch_valid_q <= 1'b0;
         fetch_pc_q    <= '0;
         misalign_q    <= 1'b0;
         br_count_q    <= '0;
         taken_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_pc_q    <= fetch_pc_d;
         misalign_q    <= misalign_d;
         br_count_q    <= br_count_d;
         taken_count_q <= taken_count_d;
      end
   end

   redirect_flush_counter #(
      .W (FLUSH_CNT_W)
   ) u_flush_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (flush_load),
      .load_val_i (FLUSH_LOAD),
      .dec_i      (flush_dec),
      .zero_o     (flush_zero)
   );

   assign imem_addr    = pc_q;
   assign fetch_valid  = fetch_valid_q;
   assign fetch_pc     = fetch_pc_q;
   assign flush_if     = (state_q == ST_FLUSH);
   assign flush_id     = (state_q == ST_FLUSH);
   assign misalign_err = misalign_q;
   assign br_count     = br_count_q;
   assign taken_count  = taken_count_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scenario bench for branch_redirect_ctrl: expected fetch PCs are queued when an
// accept is driven and compared when fetch_valid reports the returned instruction.
module tb_branch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        br_valid, br_taken, jmp_valid, stall, imem_ready;
   logic [31:0] br_target, jmp_target;
   logic        imem_req, fetch_valid, flush_if, flush_id, misalign_err;
   logic [31:0] imem_addr, fetch_pc, br_count, taken_count;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc;
   logic [31:0] exp_br;
   logic [31:0] exp_tk;

   always #5 clk = ~clk;

   branch_redirect_ctrl #(
      .XLEN         (32),
      .RESET_PC     (32'h0000_0000),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .br_valid     (br_valid),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .jmp_valid    (jmp_valid),
      .jmp_target   (jmp_target),
      .stall        (stall),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .fetch_valid  (fetch_valid),
      .fetch_pc     (fetch_pc),
      .flush_if     (flush_if),
      .flush_id     (flush_id),
      .misalign_err (misalign_err),
      .br_count     (br_count),
      .taken_count  (taken_count)
   );

   // One clock edge; outputs sampled 1ns later, returned fetches popped from the scoreboard
   task automatic tick();
      logic [31:0] e;
      @(posedge clk);
      #1;
      if (fetch_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected fetch_pc got=%h required=none", fetch_pc);
         end else begin
            e = exp_q.pop_front();
            if (fetch_pc !== e) begin
               errors++;
               $display("FAIL sb_fetch_pc got=%h required=%h", fetch_pc, e);
            end else begin
               $display("fetch returned pc=%h", fetch_pc);
            end
         end
      end
   endtask

   // One accepted sequential fetch at the model PC
   task automatic fetch_step();
      exp_q.push_back(exp_pc);
      tick();
      exp_pc = exp_pc + 32'd4;
   endtask

   task automatic clear_redirects();
      br_valid  = 1'b0;
      br_taken  = 1'b0;
      jmp_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear_redirects(); stall = 1'b0; imem_ready = 1'b1;
      br_target = '0; jmp_target = '0;
      exp_br = '0; exp_tk = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b required=0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h required=0", imem_addr); end
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL rst_fvalid got=%b required=0", fetch_valid); end
      checks++; if (flush_if !== 1'b0 || flush_id !== 1'b0) begin errors++; $display("FAIL rst_flush got=%b%b required=00", flush_if, flush_id); end
      checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign got=%b required=0", misalign_err); end
      checks++; if (br_count !== 32'h0 || taken_count !== 32'h0) begin errors++; $display("FAIL rst_counts got=%h/%h required=0/0", br_count, taken_count); end
      rst_n = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got=%b required=0", imem_req); end
      tick();
      exp_pc = 32'h0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL first_req got=%b@%h required=1@%h", imem_req, imem_addr, exp_pc); end
      $display("reset: boot cycle done, first request at %h", imem_addr);
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) begin
         fetch_step();
         checks++;
         if (imem_addr !== exp_pc || imem_req !== 1'b1) begin
            errors++; $display("FAIL seq_addr got=%b@%h required=1@%h", imem_req, imem_addr, exp_pc);
         end else begin
            $display("sequential request at %h", imem_addr);
         end
      end
   endtask

   task automatic test_branch_taken();
      br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h100;
      exp_br = exp_br + 1; exp_tk = exp_tk + 1;
      tick();
      clear_redirects();
      exp_pc = 32'h100;
      checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL br_redirect_addr got=%h required=%h", imem_addr, exp_pc); end
      checks++; if (flush_if !== 1'b1 || flush_id !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL br_flush1 got=%b%b req=%b required=11 req=0", flush_if, flush_id, imem_req); end
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL br_fvalid got=%b required=0", fetch_valid); end
      checks++; if (br_count !== exp_br || taken_count !== exp_tk) begin errors++; $display("FAIL br_counts got=%h/%h required=%h/%h", br_count, taken_count, exp_br, exp_tk); end
      tick();
      checks++; if (flush_if !== 1'b1 || flush_id !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL br_flush2 got=%b%b req=%b required=11 req=0", flush_if, flush_id, imem_req); end
      tick();
      checks++; if (flush_if !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL br_resume got=flush%b req%b@%h required=flush0 req1@%h", flush_if, imem_req, imem_addr, exp_pc); end
      $display("taken branch: redirected to %h, counts %0d/%0d", imem_addr, br_count, taken_count);
   endtask

   task automatic test_not_taken();
      br_valid = 1'b1; br_taken = 1'b0; br_target = 32'h300;
      exp_br = exp_br + 1;
      fetch_step();
      clear_redirects();
      checks++; if (imem_addr !== exp_pc || flush_if !== 1'b0) begin errors++; $display("FAIL nt_seq got=%h flush=%b required=%h flush=0", imem_addr, flush_if, exp_pc); end
      checks++; if (br_count !== exp_br || taken_count !== exp_tk) begin errors++; $display("FAIL nt_counts got=%h/%h required=%h/%h", br_count, taken_count, exp_br, exp_tk); end
      $display("not-taken branch: continued at %h", imem_addr);
   endtask

   task automatic test_jmp_priority();
      jmp_valid = 1'b1; jmp_target = 32'h200;
      br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h300;
      exp_br = exp_br + 1; exp_tk = exp_tk + 1;
      tick();
      clear_redirects();
      exp_pc = 32'h200;
      checks++; if (imem_addr !== exp_pc || flush_if !== 1'b1) begin errors++; $display("FAIL jmp_prio got=%h flush=%b required=%h flush=1", imem_addr, flush_if, exp_pc); end
      checks++; if (br_count !== exp_br || taken_count !== exp_tk) begin errors++; $display("FAIL jmp_counts got=%h/%h required=%h/%h", br_count, taken_count, exp_br, exp_tk); end
      tick();
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || flush_if !== 1'b0) begin errors++; $display("FAIL jmp_resume got=req%b@%h required=req1@%h", imem_req, imem_addr, exp_pc); end
      $display("jump+branch: jump won, pc=%h", imem_addr);
   endtask

   task automatic test_misalign();
      br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h102;
      exp_br = exp_br + 1; exp_tk = exp_tk + 1;
      tick();
      clear_redirects();
      checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_pulse got=%b required=1", misalign_err); end
      checks++; if (imem_addr !== exp_pc || flush_if !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL mis_hold got=%h flush=%b req=%b required=%h flush=0 req=1", imem_addr, flush_if, imem_req, exp_pc); end
      checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL mis_fvalid got=%b required=0", fetch_valid); end
      checks++; if (br_count !== exp_br || taken_count !== exp_tk) begin errors++; $display("FAIL mis_counts got=%h/%h required=%h/%h", br_count, taken_count, exp_br, exp_tk); end
      fetch_step();
      checks++; if (misalign_err !== 1'b0 || imem_addr !== exp_pc) begin errors++; $display("FAIL mis_after got=err%b@%h required=err0@%h", misalign_err, imem_addr, exp_pc); end
      $display("misaligned target: error pulsed, pc kept, now %h", imem_addr);
   endtask

   task automatic test_ready_hold();
      imem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== exp_pc || fetch_valid !== 1'b0) begin
            errors++; $display("FAIL wait_hold got=req%b@%h fv=%b required=req1@%h fv=0", imem_req, imem_addr, fetch_valid, exp_pc);
         end
      end
      imem_ready = 1'b1;
      fetch_step();
      checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL wait_release got=%h required=%h", imem_addr, exp_pc); end
      $display("ready low: request held, then accepted, now %h", imem_addr);
   endtask

   task automatic test_stall_redirect();
      stall = 1'b1; imem_ready = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got=%b required=0", imem_req); end
      tick();
      checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL stall_hold got=%h required=%h", imem_addr, exp_pc); end
      jmp_valid = 1'b1; jmp_target = 32'h400;
      tick();
      clear_redirects();
      checks++; if (imem_addr !== 32'h400 || flush_if !== 1'b1) begin errors++; $display("FAIL stall_redir got=%h flush=%b required=00000400 flush=1", imem_addr, flush_if); end
      jmp_valid = 1'b1; jmp_target = 32'h500;
      tick();
      clear_redirects();
      checks++; if (imem_addr !== 32'h500 || flush_id !== 1'b1) begin errors++; $display("FAIL flush_redir got=%h flush=%b required=00000500 flush=1", imem_addr, flush_id); end
      tick();
      checks++; if (flush_if !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL flush_reload got=flush%b req%b required=flush1 req0", flush_if, imem_req); end
      stall = 1'b0; imem_ready = 1'b1;
      tick();
      exp_pc = 32'h500;
      checks++; if (flush_if !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL flush_exit got=flush%b req%b@%h required=flush0 req1@%h", flush_if, imem_req, imem_addr, exp_pc); end
      fetch_step();
      checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL post_flush_seq got=%h required=%h", imem_addr, exp_pc); end
      $display("stall+redirect: flush reloaded, first request at 00000500");
   endtask

   task automatic test_reset_mid_flush();
      jmp_valid = 1'b1; jmp_target = 32'h600;
      tick();
      clear_redirects();
      checks++; if (flush_if !== 1'b1) begin errors++; $display("FAIL pre_rst_flush got=%b required=1", flush_if); end
      #1 rst_n = 1'b0;
      #1;
      exp_br = '0; exp_tk = '0;
      checks++; if (imem_addr !== 32'h0 || flush_if !== 1'b0 || flush_id !== 1'b0) begin errors++; $display("FAIL async_rst got=%h flush=%b%b required=0 flush=00", imem_addr, flush_if, flush_id); end
      checks++; if (br_count !== exp_br || taken_count !== exp_tk || fetch_valid !== 1'b0) begin errors++; $display("FAIL async_rst_cnt got=%h/%h fv=%b required=0/0 fv=0", br_count, taken_count, fetch_valid); end
      tick();
      rst_n = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reboot_req got=%b required=0", imem_req); end
      tick();
      exp_pc = 32'h0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== exp_pc || flush_if !== 1'b0) begin errors++; $display("FAIL reboot_first got=req%b@%h required=req1@%h", imem_req, imem_addr, exp_pc); end
      fetch_step();
      $display("reset mid-flush: pending redirect dropped, restarted at 00000000");
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch_taken();
      test_not_taken();
      test_jmp_priority();
      test_misalign();
      test_ready_hold();
      test_stall_redirect();
      test_reset_mid_flush();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got=%0d pending required=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Fetch-side consumer of the branch comparator's taken flag: owns the program counter.
- Issues sequential instruction-memory requests, and on a resolved taken branch or jump redirects the PC and flushes IF/ID for a fixed number of cycles.
- Static predict-not-taken; sits between the execute-stage branch/jump logic and instruction memory.
- Also keeps branch statistics counters.

Parameters:
- XLEN, 32, PC/target width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- FLUSH_CYCLES, 2, cycles flush_if/flush_id stay high after a redirect (legal 1..7)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- br_valid  in  1  EX stage holds a resolved conditional branch this cycle
- br_taken  in  1  comparator result, sampled only when br_valid
- br_target  in  XLEN  branch target
- jmp_valid  in  1  JAL/JALR resolved this cycle (always taken)
- jmp_target  in  XLEN  jump target
- stall  in  1  hazard-unit stall; freezes PC advance
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address (equals pc)
- imem_ready  in  1  memory accepts/returns in the cycle req&ready
- fetch_valid  out  1  registered; the instruction at fetch_pc was returned last cycle
- fetch_pc  out  XLEN  registered PC of that instruction
- flush_if  out  1  kill IF/ID register contents
- flush_id  out  1  kill ID/EX register contents
- misalign_err  out  1  one-cycle pulse, redirect target[1:0] != 0
- br_count  out  32  resolved conditional branches (wraps)
- taken_count  out  32  taken conditional branches (wraps)

Behaviour:
- Reset values (async on rst_n low): pc=RESET_PC, state=BOOT, all outputs 0 except imem_addr=RESET_PC; counters 0.
- States: BOOT, FETCH, FLUSH.
  - BOOT: one cycle, imem_req=0, then FETCH. This guarantees a clean first request after reset release.
  - FETCH: imem_req=1 unless stall. imem_addr=pc.
  - FLUSH: imem_req=0. flush_if=flush_id=1. A down-counter is loaded with FLUSH_CYCLES-1; the FSM returns to FETCH when it reaches 0.
- Advance: in FETCH, if imem_req & imem_ready & no redirect, then pc<=pc+4 (mod 2^XLEN, wraps silently), fetch_valid<=1, fetch_pc<=pc. Otherwise fetch_valid<=0.
- Memory is non-pipelined; a request with imem_ready=0 holds pc/addr stable and may be abandoned only by a redirect.
- Redirect event: jmp_valid, or br_valid&br_taken.
  - jmp_valid has priority over the branch when both are asserted; the branch is still counted.
  - Aligned target: pc<=target next edge, state<=FLUSH, fetch_valid<=0.
  - Misaligned target: no redirect, pc unchanged. misalign_err pulses the next cycle. No flush.
- Redirect overrides stall, and is accepted in any state except BOOT. In FLUSH it reloads the flush counter and the new target wins.
- br_valid&~br_taken: no PC effect (prediction correct), br_count++ only.
- Counters increment on br_valid (br_count), and on br_valid&br_taken (taken_count). They increment even for misaligned targets and wrap from FFFF_FFFF to 0.
- Reset asserted mid-FLUSH or mid-request: immediate return to reset values; no pending redirect survives.

Decomposition:
- Shared package holds:
  - state encoding typedef (BOOT/FETCH/FLUSH)
  - PC_INCR=4
  - RESET_PC default
  - alignment mask constant
- One natural sub-module: redirect_flush_counter, a loadable down-counter with zero flag, reused by the future data-side flush logic.
- Everything else stays inline.

Test Plan:
- Reset release, imem_ready=1 constantly:
  - no req in the BOOT cycle
  - then imem_addr 0x0, 0x4, 0x8
  - fetch_valid rises one cycle after each accept, with fetch_pc 0x0, 0x4.
- At pc=0x10, br_valid=1, br_taken=1, br_target=0x100:
  - next cycle pc=0x100, flush_if=flush_id=1 for exactly 2 cycles, imem_req=0 during them
  - then req at 0x100
  - br_count=1, taken_count=1.
- br_valid=1, br_taken=0 at pc=0x20 → no flush, sequence continues 0x24; br_count=1, taken_count=0.
- jmp_valid with jmp_target=0x200 and br_valid&br_taken with br_target=0x300 in the same cycle → pc=0x200, br_count=1, taken_count=1.
- br_target=0x102, taken → misalign_err one-cycle pulse, pc unchanged, no flush.
- stall=1 with imem_ready=0 held 3 cycles, redirect to 0x400 in cycle 2 → pc=0x400, FLUSH entered despite stall. Second redirect to 0x500 during FLUSH → flush counter reloads, first req at 0x500.
